lsu_store_unit: RTL and testbench

//  Store/address side of the single-cycle LSU. Decodes the effective address and generates the 2-bit read-source select.
//  It owns the memory-mapped output buffer registers (LEDR, LEDG, HEX, LCD), synchronises the switch inputs into the input buffer,
//  and lane-aligns store data for data memory.
//  Its outputs feed the LSU load-return mux: input buffer, output buffer, data memory.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_store_align.sv | 38 +++
 rtl/lsu_store_unit.sv | 125 ++++++++++++
 tb/tb_lsu_store_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and types for the LSU store/address side.
// Page bases, store funct3 codes and the load-return source select.
package lsu_pkg;

  localparam int DMEM_DEPTH = 2048;
  localparam int NUM_OUT    = 5;

  localparam logic [19:0] PG_LEDR   = 20'h10000;
  localparam logic [19:0] PG_LEDG   = 20'h10001;
  localparam logic [19:0] PG_HEX_LO = 20'h10002;
  localparam logic [19:0] PG_HEX_HI = 20'h10003;
  localparam logic [19:0] PG_LCD    = 20'h10004;
  localparam logic [19:0] PG_SW     = 20'h10010;

  localparam logic [19:0] OUT_PG [NUM_OUT] = '{
    PG_LEDR, PG_LEDG, PG_HEX_LO, PG_HEX_HI, PG_LCD
  };

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } st_f3_e;

  typedef enum logic [1:0] {
    SEL_IN   = 2'b00,
    SEL_OUT  = 2'b01,
    SEL_DMEM = 2'b10,
    SEL_NONE = 2'b11
  } sel_e;

  function automatic logic [31:0] bmask32(
    input logic [3:0] m
  );
    return {{8{m[3]}}, {8{m[2]}},
            {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/lsu_store_align.sv
// lsu_store_align: store lane alignment and legality check.
// Pure combinational; funct3 + addr[1:0] + data -> mask/data/faults.
module lsu_store_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [3:0]  bytemask,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic        illegal
);

  always_comb begin
    bytemask   = '0;
    wdata      = data;
    misaligned = 1'b0;
    illegal    = 1'b0;
    unique case (1'b1)
      funct3 == F3_SB: begin
        bytemask = 4'b0001 << addr_lo;
        wdata    = {4{data[7:0]}};
      end
      funct3 == F3_SH: begin
        bytemask   = 4'b0011 << {addr_lo[1], 1'b0};
        wdata      = {2{data[15:0]}};
        misaligned = addr_lo[0];
      end
      funct3 == F3_SW: begin
        bytemask   = 4'b1111;
        misaligned = |addr_lo;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_store_unit.sv
// lsu_store_unit: address decode, MMIO output registers, switch
// synchroniser, store alignment and sticky store-fault capture.
module lsu_store_unit
  import lsu_pkg::*;
#(
  parameter int DMEM_DEPTH_BYTES = DMEM_DEPTH,
  parameter int SW_WIDTH         = 18
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [31:0]         i_lsu_addr,
  input  logic [31:0]         i_st_data,
  input  logic [2:0]          i_funct3,
  input  logic                i_lsu_wren,
  input  logic [SW_WIDTH-1:0] i_io_sw,
  output logic [1:0]          o_sel_output_lsu,
  output logic [31:0]         o_input_buffer,
  output logic [31:0]         o_output_buffer,
  output logic                o_dmem_wren,
  output logic [3:0]          o_dmem_bytemask,
  output logic [31:0]         o_dmem_wdata,
  output logic [31:0]         o_io_ledr,
  output logic [31:0]         o_io_ledg,
  output logic [31:0]         o_io_hex_lo,
  output logic [31:0]         o_io_hex_hi,
  output logic [31:0]         o_io_lcd,
  output logic                o_store_fault,
  output logic [31:0]         o_fault_addr
);

  logic [19:0]         pg;
  logic                is_dmem;
  logic                is_sw;
  logic [NUM_OUT-1:0]  ohit;
  sel_e                sel;
  logic                misaligned;
  logic                illegal;
  logic                fault_now;
  logic                legal;
  logic [31:0]         m32;
  logic [31:0]         rdbk;
  logic [31:0]         outreg [NUM_OUT];
  logic [SW_WIDTH-1:0] sync1;
  logic [SW_WIDTH-1:0] sync2;

  assign pg      = i_lsu_addr[31:12];
  assign is_dmem = i_lsu_addr < 32'(DMEM_DEPTH_BYTES);
  assign is_sw   = pg == PG_SW;

  always_comb begin
    ohit = '0;
    for (int i = 0; i < NUM_OUT; i++)
      ohit[i] = pg == OUT_PG[i];
  end

  always_comb begin
    sel = SEL_NONE;
    unique case (1'b1)
      is_sw:   sel = SEL_IN;
      |ohit:   sel = SEL_OUT;
      is_dmem: sel = SEL_DMEM;
      default: sel = SEL_NONE;
    endcase
  end

  assign o_sel_output_lsu = sel;

  lsu_store_align u_align (
    .funct3     (i_funct3),
    .addr_lo    (i_lsu_addr[1:0]),
    .data       (i_st_data),
    .bytemask   (o_dmem_bytemask),
    .wdata      (o_dmem_wdata),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  // SW page is read-only, so a store there faults like unmapped
  assign fault_now = i_lsu_wren &
                     (misaligned | illegal |
                      (sel == SEL_NONE) | is_sw);
  assign legal       = i_lsu_wren & ~fault_now;
  assign o_dmem_wren = legal & is_dmem & ~i_reset;
  assign m32         = bmask32(o_dmem_bytemask);

  always_comb begin
    rdbk = '0;
    for (int i = 0; i < NUM_OUT; i++)
      if (ohit[i]) rdbk = outreg[i];
  end

  assign o_output_buffer = rdbk;
  assign o_input_buffer  =
    {{(32-SW_WIDTH){1'b0}}, sync2};

  assign o_io_ledr   = outreg[0];
  assign o_io_ledg   = outreg[1];
  assign o_io_hex_lo = outreg[2];
  assign o_io_hex_hi = outreg[3];
  assign o_io_lcd    = outreg[4];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_OUT; i++)
        outreg[i] <= '0;
      sync1         <= '0;
      sync2         <= '0;
      o_store_fault <= 1'b0;
      o_fault_addr  <= '0;
    end else begin
      sync1 <= i_io_sw;
      sync2 <= sync1;
      if (fault_now) begin
        o_store_fault <= 1'b1;
        if (!o_store_fault)
          o_fault_addr <= i_lsu_addr;
      end
      for (int i = 0; i < NUM_OUT; i++)
        if (legal && ohit[i])
          outreg[i] <= (outreg[i] & ~m32) |
                       (o_dmem_wdata & m32);
    end
  end

endmodule

// File: tb/tb_lsu_store_unit.sv
// tb_lsu_store_unit: directed sequences, a constant vector table and
// random stores checked against a region/byte-level reference model.
module tb_lsu_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] d;
  logic [2:0]  f;
  logic        w;
  logic [17:0] sw;

  logic [1:0]  o_sel;
  logic [31:0] o_ib;
  logic [31:0] o_ob;
  logic        o_wren;
  logic [3:0]  o_mask;
  logic [31:0] o_wd;
  logic [31:0] o_ledr;
  logic [31:0] o_ledg;
  logic [31:0] o_hlo;
  logic [31:0] o_hhi;
  logic [31:0] o_lcd;
  logic        o_fault;
  logic [31:0] o_faddr;

  int errs   = 0;
  int checks = 0;

  logic [31:0] mreg [5];
  logic        mfault;
  logic [31:0] mfaddr;
  logic [17:0] swq [$];

  always #5 clk = ~clk;

  lsu_store_unit dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_lsu_addr       (a),
    .i_st_data        (d),
    .i_funct3         (f),
    .i_lsu_wren       (w),
    .i_io_sw          (sw),
    .o_sel_output_lsu (o_sel),
    .o_input_buffer   (o_ib),
    .o_output_buffer  (o_ob),
    .o_dmem_wren      (o_wren),
    .o_dmem_bytemask  (o_mask),
    .o_dmem_wdata     (o_wd),
    .o_io_ledr        (o_ledr),
    .o_io_ledg        (o_ledg),
    .o_io_hex_lo      (o_hlo),
    .o_io_hex_hi      (o_hhi),
    .o_io_lcd         (o_lcd),
    .o_store_fault    (o_fault),
    .o_fault_addr     (o_faddr)
  );

  function automatic void chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endfunction

  // 0..4 output regs, 5 switch page, 6 dmem, 7 unmapped
  function automatic int region(input logic [31:0] x);
    if (x < 32'd2048) return 6;
    if (x >= 32'h1000_0000 && x < 32'h1000_5000)
      return int'((x - 32'h1000_0000) / 32'h1000);
    if (x >= 32'h1001_0000 && x < 32'h1001_1000)
      return 5;
    return 7;
  endfunction

  function automatic int size_of(input logic [2:0] ff);
    if (ff == 3'd0) return 1;
    if (ff == 3'd1) return 2;
    if (ff == 3'd2) return 4;
    return 0;
  endfunction

  function automatic bit legal_store();
    int r;
    int sz;
    r  = region(a);
    sz = size_of(f);
    if (!w || sz == 0) return 1'b0;
    if ((a % 32'(sz)) != 0) return 1'b0;
    return (r <= 4) || (r == 6);
  endfunction

  task automatic check_comb();
    int r;
    int sz;
    int off;
    bit ew;
    logic [1:0] es;
    r   = region(a);
    sz  = size_of(f);
    off = int'(a[1:0]);
    es  = (r <= 4) ? 2'd1 : (r == 5) ? 2'd0 :
          (r == 6) ? 2'd2 : 2'd3;
    ew  = legal_store() && r == 6 && !rst;
    chk("sel", 32'(o_sel), 32'(es));
    chk("readback", o_ob, (r <= 4) ? mreg[r] : 32'd0);
    chk("inbuf", o_ib, {14'd0, swq[0]});
    chk("dmem_wren", 32'(o_wren), 32'(ew));
    if (ew) begin
      for (int k = 0; k < 4; k++) begin
        bit in;
        in = k >= off && k < off + sz;
        chk("mask_bit", 32'(o_mask[k]), 32'(in));
        if (in)
          chk("wdata_lane", 32'(o_wd[8*k +: 8]),
              32'(d[8*(k-off) +: 8]));
      end
    end
    chk("ledr", o_ledr, mreg[0]);
    chk("ledg", o_ledg, mreg[1]);
    chk("hex_lo", o_hlo, mreg[2]);
    chk("hex_hi", o_hhi, mreg[3]);
    chk("lcd", o_lcd, mreg[4]);
    chk("fault", 32'(o_fault), 32'(mfault));
    chk("fault_addr", o_faddr, mfaddr);
  endtask

  task automatic clk_edge();
    int r;
    int sz;
    int off;
    bit ok;
    @(posedge clk);
    r   = region(a);
    sz  = size_of(f);
    off = int'(a[1:0]);
    ok  = legal_store();
    if (rst) begin
      for (int i = 0; i < 5; i++) mreg[i] = '0;
      mfault = 1'b0;
      mfaddr = '0;
      swq    = '{18'd0, 18'd0};
    end else begin
      swq.push_back(sw);
      void'(swq.pop_front());
      if (w && !ok) begin
        if (!mfault) mfaddr = a;
        mfault = 1'b1;
      end else if (ok && r <= 4) begin
        for (int k = off; k < off + sz; k++)
          mreg[r][8*k +: 8] = d[8*(k-off) +: 8];
      end
    end
    #1;
  endtask

  task automatic tick();
    check_comb();
    clk_edge();
  endtask

  task automatic drv(
    input logic [31:0] aa,
    input logic [31:0] dd,
    input logic [2:0]  ff,
    input logic        ww
  );
    a = aa;
    d = dd;
    f = ff;
    w = ww;
    #3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv(32'h0, 32'h0, 3'd2, 1'b0);
    clk_edge();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
    logic [1:0]  sel;
    logic        wr;
    logic [3:0]  m;
    logic [31:0] wd;
  } vec_t;

  vec_t tbl [$];

  initial begin
    tbl.push_back('{32'h0000_0000, 32'hDEAD_BEEF, 3'd2,
                    2'd2, 1'b1, 4'hF, 32'hDEAD_BEEF});
    tbl.push_back('{32'h0000_0012, 32'h1234_5678, 3'd1,
                    2'd2, 1'b1, 4'hC, 32'h5678_5678});
    tbl.push_back('{32'h0000_0007, 32'h0000_00A5, 3'd0,
                    2'd2, 1'b1, 4'h8, 32'hA5A5_A5A5});
    tbl.push_back('{32'h0000_0004, 32'h1122_3344, 3'd0,
                    2'd2, 1'b1, 4'h1, 32'h4444_4444});
    tbl.push_back('{32'h0000_0010, 32'hCAFE_BABE, 3'd1,
                    2'd2, 1'b1, 4'h3, 32'hBABE_BABE});
    tbl.push_back('{32'h0000_07FC, 32'h0102_0304, 3'd2,
                    2'd2, 1'b1, 4'hF, 32'h0102_0304});
    tbl.push_back('{32'h0000_0800, 32'h1, 3'd2,
                    2'd3, 1'b0, 4'h0, 32'h0});
    tbl.push_back('{32'h1000_1000, 32'h2, 3'd2,
                    2'd1, 1'b0, 4'h0, 32'h0});
    tbl.push_back('{32'h1001_0000, 32'h3, 3'd2,
                    2'd0, 1'b0, 4'h0, 32'h0});
    tbl.push_back('{32'h0000_0010, 32'h4, 3'd3,
                    2'd2, 1'b0, 4'h0, 32'h0});
    tbl.push_back('{32'h0000_0013, 32'h5, 3'd1,
                    2'd2, 1'b0, 4'h0, 32'h0});
    tbl.push_back('{32'h2000_0000, 32'h6, 3'd0,
                    2'd3, 1'b0, 4'h0, 32'h0});
    tbl.push_back('{32'h1000_5000, 32'h7, 3'd0,
                    2'd3, 1'b0, 4'h0, 32'h0});
    tbl.push_back('{32'h1001_1000, 32'h8, 3'd0,
                    2'd3, 1'b0, 4'h0, 32'h0});
    tbl.push_back('{32'h1000_4001, 32'h5A, 3'd0,
                    2'd1, 1'b0, 4'h0, 32'h0});

    sw = '0;
    do_reset();

    chk("rst_ledr", o_ledr, 32'h0);
    chk("rst_lcd", o_lcd, 32'h0);
    chk("rst_fault", 32'(o_fault), 32'h0);
    chk("rst_faddr", o_faddr, 32'h0);
    chk("rst_inbuf", o_ib, 32'h0);

    drv(32'h1000_0000, 32'hDEAD_BEEF, 3'd2, 1'b1);
    chk("t1_sel", 32'(o_sel), 32'h1);
    chk("t1_old_rdbk", o_ob, 32'h0);
    tick();
    drv(32'h1000_0000, 32'h0, 3'd2, 1'b0);
    chk("t1_ledr", o_ledr, 32'hDEAD_BEEF);
    chk("t1_rdbk", o_ob, 32'hDEAD_BEEF);
    tick();

    drv(32'h1000_2003, 32'h0000_00A5, 3'd0, 1'b1);
    chk("t2_old_rdbk", o_ob, 32'h0);
    tick();
    chk("t2_hex_lo", o_hlo, 32'hA500_0000);

    drv(32'h0000_0012, 32'h1234_5678, 3'd1, 1'b1);
    chk("t3_wren", 32'(o_wren), 32'h1);
    chk("t3_mask", 32'(o_mask), 32'hC);
    chk("t3_wdata", o_wd, 32'h5678_5678);
    chk("t3_sel", 32'(o_sel), 32'h2);
    tick();

    drv(32'h0000_0102, 32'h1111_1111, 3'd2, 1'b1);
    chk("t4_wren", 32'(o_wren), 32'h0);
    tick();
    chk("t4_fault", 32'(o_fault), 32'h1);
    chk("t4_faddr", o_faddr, 32'h102);
    drv(32'h2000_0000, 32'h22, 3'd0, 1'b1);
    chk("t4_sel", 32'(o_sel), 32'h3);
    tick();
    chk("t4_fault2", 32'(o_fault), 32'h1);
    chk("t4_faddr2", o_faddr, 32'h102);

    do_reset();
    sw = 18'h3FFFF;
    drv(32'h1001_0000, 32'h0, 3'd2, 1'b0);
    chk("t5_ib_t0", o_ib, 32'h0);
    tick();
    chk("t5_ib_t1", o_ib, 32'h0);
    tick();
    chk("t5_ib_t2", o_ib, 32'h0003_FFFF);
    drv(32'h1001_0000, 32'hFFFF_FFFF, 3'd2, 1'b1);
    chk("t5_sw_wren", 32'(o_wren), 32'h0);
    tick();
    chk("t5_sw_fault", 32'(o_fault), 32'h1);
    chk("t5_sw_ledr", o_ledr, 32'h0);

    drv(32'h1000_1000, 32'h55AA_55AA, 3'd2, 1'b1);
    tick();
    chk("t6_pre_ledg", o_ledg, 32'h55AA_55AA);
    rst = 1'b1;
    drv(32'h0000_0020, 32'h1, 3'd2, 1'b1);
    chk("t6_dmem_rst_wren", 32'(o_wren), 32'h0);
    drv(32'h1000_1000, 32'hFFFF_FFFF, 3'd2, 1'b1);
    chk("t6_rst_wren", 32'(o_wren), 32'h0);
    tick();
    rst = 1'b0;
    chk("t6_ledg", o_ledg, 32'h0);
    chk("t6_fault", 32'(o_fault), 32'h0);

    do_reset();
    foreach (tbl[i]) begin
      drv(tbl[i].a, tbl[i].d, tbl[i].f, 1'b1);
      chk("tbl_sel", 32'(o_sel), 32'(tbl[i].sel));
      chk("tbl_wren", 32'(o_wren), 32'(tbl[i].wr));
      if (tbl[i].wr) begin
        chk("tbl_mask", 32'(o_mask), 32'(tbl[i].m));
        chk("tbl_wdata", o_wd, tbl[i].wd);
      end
      tick();
    end
    chk("tbl_lcd", o_lcd, 32'h0000_5A00);
    chk("tbl_faddr", o_faddr, 32'h0000_0800);

    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ra;
      rst = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0)
        sw = 18'($urandom);
      case ($urandom_range(0, 4))
        0: ra = 32'($urandom_range(0, 2047));
        1: ra = 32'h1000_0000 +
                32'($urandom_range(0, 4)) * 32'h1000 +
                32'($urandom_range(0, 4095));
        2: ra = 32'h1001_0000 + 32'($urandom_range(0, 15));
        3: ra = $urandom;
        default: ra = 32'd2040 + 32'($urandom_range(0, 15));
      endcase
      drv(ra, $urandom,
          ($urandom_range(0, 7) == 0) ?
            3'($urandom_range(3, 7)) :
            3'($urandom_range(0, 2)),
          $urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
